// File: rtl/sv32_translate_tlb.sv
// SV32 virtual-to-physical translator shared by fetch, load and store, with a small
// fully-associative TLB in front of the external page-table walker.
module sv32_translate_tlb #(
  parameter int TLB_ENTRIES = 4,
  parameter int ASID_W      = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  output logic        ready,
  input  logic [31:0] address,
  input  logic [1:0]  access_type,
  input  logic [1:0]  privilege_mode,
  input  logic [31:0] satp,
  input  logic        mxr,
  input  logic        sum,
  input  logic        sfence_vma,
  output logic [33:0] physical_address,
  output logic        page_fault,
  output logic        walk_valid,
  input  logic        walk_ready,
  input  logic [31:0] pte,
  input  logic        pte_megapage
);

  localparam int IDX_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRIES - 1);
  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_M = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_WALK, ST_CHECK} state_t;

  typedef struct packed {
    logic [9:0]        vpn1;
    logic [9:0]        vpn0;
    logic [ASID_W-1:0] asid;
    logic [21:0]       ppn;
    logic              r, w, x, u, g, a, d;
    logic              mega;
  } tlb_entry_t;

  state_t state, state_next;

  tlb_entry_t             tlb_data [TLB_ENTRIES];
  logic [TLB_ENTRIES-1:0] tlb_valid;
  logic [IDX_W-1:0]       rr_ptr;

  logic [31:0]       req_va;
  logic [1:0]        req_acc;
  logic [1:0]        req_priv;
  logic              req_mxr;
  logic              req_sum;
  logic [ASID_W-1:0] req_asid;
  logic [31:0]       walk_pte;
  logic              walk_mega;
  logic              no_fill;

  logic [ASID_W-1:0] satp_asid;
  logic              bypass;
  logic              accept;
  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic              hit_fault;
  logic [33:0]       hit_pa;
  logic              walk_fault;
  logic [33:0]       walk_pa;
  logic              walk_fillable;
  logic              fill_en;
  logic              unused_bits;

  // Permission/legality rules shared by the hit path and the walked PTE.
  function automatic logic pte_fault(
    input logic       v, r, w, x, u, a, d, mega,
    input logic [9:0] ppn_lo,
    input logic [1:0] acc,
    input logic [1:0] priv,
    input logic       mxr_f,
    input logic       sum_f
  );
    logic fetch, load, store, u_mode;
    fetch  = (acc == 2'd0);
    load   = (acc == 2'd1);
    store  = acc[1];
    u_mode = (priv == PRIV_U);
    return !v || (w && !r) || (mega && (ppn_lo != 10'd0)) || !a
        || (store && !d) || (fetch && !x) || (load && !(r || (mxr_f && x)))
        || (store && !w) || (u_mode && !u)
        || (!u_mode && fetch && u) || (!u_mode && !fetch && u && !sum_f);
  endfunction

  function automatic logic [33:0] form_pa(input logic [21:0] ppn, input logic mega,
                                          input logic [31:0] va);
    return mega ? {ppn[21:10], va[21:0]} : {ppn, va[11:0]};
  endfunction

  assign satp_asid  = satp[22 +: ASID_W];
  assign bypass     = (privilege_mode == PRIV_M) || !satp[31];
  assign accept     = (state == ST_IDLE) && valid && !ready;
  assign walk_valid = (state == ST_WALK);

  // Lowest matching index wins: scan downwards so the last assignment is the lowest.
  // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (tlb_valid[i] && (tlb_data[i].g || (tlb_data[i].asid == satp_asid)) &&
          (tlb_data[i].vpn1 == address[31:22]) &&
          (tlb_data[i].mega || (tlb_data[i].vpn0 == address[21:12]))) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign hit_fault = pte_fault(1'b1, tlb_data[hit_idx].r, tlb_data[hit_idx].w,
                               tlb_data[hit_idx].x, tlb_data[hit_idx].u,
                               tlb_data[hit_idx].a, tlb_data[hit_idx].d,
                               tlb_data[hit_idx].mega, tlb_data[hit_idx].ppn[9:0],
                               access_type, privilege_mode, mxr, sum);
  assign hit_pa    = form_pa(tlb_data[hit_idx].ppn, tlb_data[hit_idx].mega, address);

  assign walk_fault = pte_fault(walk_pte[0], walk_pte[1], walk_pte[2], walk_pte[3],
                                walk_pte[4], walk_pte[6], walk_pte[7], walk_mega,
                                walk_pte[19:10], req_acc, req_priv, req_mxr, req_sum);
  assign walk_pa    = form_pa(walk_pte[31:10], walk_mega, req_va);

  // Permission and A/D faults still fill: permissions are re-checked on every hit.
  assign walk_fillable = walk_pte[0] && !(walk_pte[2] && !walk_pte[1]) &&
                         !(walk_mega && (walk_pte[19:10] != 10'd0));
  assign fill_en       = (state == ST_CHECK) && walk_fillable && !no_fill && !sfence_vma;

  assign unused_bits = ^{satp, walk_pte[9:8]};

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept && !bypass && !hit) state_next = ST_WALK;
      ST_WALK:  if (walk_ready) state_next = ST_CHECK;
      ST_CHECK: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready            <= 1'b0;
      page_fault       <= 1'b0;
      physical_address <= '0;
      tlb_valid        <= '0;
      rr_ptr           <= '0;
      no_fill          <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (accept) begin
        no_fill <= 1'b0;
        if (bypass) begin
          ready            <= 1'b1;
          page_fault       <= 1'b0;
          physical_address <= {2'b00, address};
        end else if (hit) begin
          ready            <= 1'b1;
          page_fault       <= hit_fault;
          physical_address <= hit_fault ? '0 : hit_pa;
        end
      end
      if (state == ST_CHECK) begin
        ready            <= 1'b1;
        page_fault       <= walk_fault;
        physical_address <= walk_fault ? '0 : walk_pa;
        if (fill_en) begin
          tlb_valid[rr_ptr] <= 1'b1;
          rr_ptr            <= (rr_ptr == LAST_IDX) ? '0 : rr_ptr + 1'b1;
        end
      end
      // A flush mid-walk still returns the in-flight result but must not refill.
      if (sfence_vma) begin
        tlb_valid <= '0;
        if (state != ST_IDLE) no_fill <= 1'b1;
      end
    end
  end

  // NOTE: payload storage is deliberately not reset; it is only ever read behind a valid bit or FSM state.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_va   <= address;
      req_acc  <= access_type;
      req_priv <= privilege_mode;
      req_mxr  <= mxr;
      req_sum  <= sum;
      req_asid <= satp_asid;
    end
    if ((state == ST_WALK) && walk_ready) begin
      walk_pte  <= pte;
      walk_mega <= pte_megapage;
    end
    if (fill_en) begin
      tlb_data[rr_ptr] <= '{vpn1: req_va[31:22], vpn0: req_va[21:12], asid: req_asid,
                            ppn: walk_pte[31:10], r: walk_pte[1], w: walk_pte[2],
                            x: walk_pte[3], u: walk_pte[4], g: walk_pte[5],
                            a: walk_pte[6], d: walk_pte[7], mega: walk_mega};
    end
  end

endmodule

// File: tb/tb_sv32_translate_tlb.sv
// Self-checking bench for sv32_translate_tlb: directed spec scenarios plus randomized
// traffic, all scored against a table-level TLB/permission model.
module tb_sv32_translate_tlb;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic        ready;
  logic [31:0] address;
  logic [1:0]  access_type;
  logic [1:0]  privilege_mode;
  logic [31:0] satp;
  logic        mxr;
  logic        sum;
  logic        sfence_vma;
  logic [33:0] physical_address;
  logic        page_fault;
  logic        walk_valid;
  logic        walk_ready;
  logic [31:0] pte;
  logic        pte_megapage;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sv32_translate_tlb #(.TLB_ENTRIES(N), .ASID_W(9)) dut (
    .clk(clk), .reset(reset), .valid(valid), .ready(ready), .address(address),
    .access_type(access_type), .privilege_mode(privilege_mode), .satp(satp),
    .mxr(mxr), .sum(sum), .sfence_vma(sfence_vma), .physical_address(physical_address),
    .page_fault(page_fault), .walk_valid(walk_valid), .walk_ready(walk_ready),
    .pte(pte), .pte_megapage(pte_megapage)
  );

  typedef struct {
    logic [31:0] va;
    logic [1:0]  acc;
    logic [1:0]  priv;
    logic        mxr;
    logic        sum;
    logic [31:0] wpte;
    logic        wmega;
  } req_t;

  typedef struct {
    bit          v;
    logic [19:0] vpn;
    logic [8:0]  asid;
    logic [31:0] pte;
    bit          mega;
  } ment_t;

  ment_t mtlb [N];
  int    m_rr;

  localparam logic [31:0] SATP_S5 = 32'h8140_0000;  // MODE=1, ASID=5

  function automatic logic [31:0] mk_pte(input logic [21:0] ppn, input logic [7:0] flags);
    return {ppn, 2'b00, flags};
  endfunction

  function automatic req_t mkreq(input logic [31:0] va, input logic [1:0] acc,
                                 input logic [1:0] priv, input logic m, input logic s,
                                 input logic [31:0] wpte, input logic wmega);
    req_t r;
    r.va = va; r.acc = acc; r.priv = priv; r.mxr = m; r.sum = s;
    r.wpte = wpte; r.wmega = wmega;
    return r;
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < N; i++) mtlb[i].v = 1'b0;
  endfunction

  // Fault rules written straight from the access-permission table.
  function automatic bit rule_fault(input logic [31:0] p, input bit mega, input req_t r);
    bit fetch, load, store, umode, smode;
    fetch = (r.acc == 2'd0); load = (r.acc == 2'd1); store = (r.acc >= 2'd2);
    umode = (r.priv == 2'd0); smode = (r.priv == 2'd1);
    if (!p[0]) return 1'b1;
    if (p[2] && !p[1]) return 1'b1;
    if (mega && (p[19:10] != 10'd0)) return 1'b1;
    if (!p[6]) return 1'b1;
    if (store && !p[7]) return 1'b1;
    if (fetch && !p[3]) return 1'b1;
    if (load && !(p[1] || (r.mxr && p[3]))) return 1'b1;
    if (store && !p[2]) return 1'b1;
    if (umode && !p[4]) return 1'b1;
    if (smode && fetch && p[4]) return 1'b1;
    if (smode && !fetch && p[4] && !r.sum) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [33:0] rule_pa(input logic [31:0] p, input bit mega,
                                          input logic [31:0] va);
    longint unsigned ppn, v, pa;
    ppn = p[31:10];
    v   = va;
    if (mega) pa = (ppn / 1024) * 64'h40_0000 + (v % 64'h40_0000);
    else      pa = ppn * 4096 + (v % 4096);
    return 34'(pa);
  endfunction

  // sf: 0 none, 1 sfence pulse during the walk, 2 sfence pulse on the acceptance cycle.
  task automatic predict(input req_t r, input int sf, output logic [33:0] epa,
                         output logic epf, output bit ewalk);
    int          hit_i;
    logic [31:0] p;
    bit          mega;
    hit_i = -1;
    if (r.priv == 2'd3 || !satp[31]) begin
      epa = {2'b00, r.va}; epf = 1'b0; ewalk = 1'b0;
      if (sf == 2) model_flush();
      return;
    end
    for (int i = 0; i < N; i++)
      if (hit_i < 0 && mtlb[i].v && (mtlb[i].pte[5] || mtlb[i].asid == satp[30:22]) &&
          mtlb[i].vpn[19:10] == r.va[31:22] &&
          (mtlb[i].mega || mtlb[i].vpn[9:0] == r.va[21:12]))
        hit_i = i;
    ewalk = (hit_i < 0);
    if (!ewalk) begin
      p = mtlb[hit_i].pte; mega = mtlb[hit_i].mega;
      if (sf == 2) model_flush();
    end else begin
      p = r.wpte; mega = r.wmega;
      if (sf != 0) model_flush();
      if (p[0] && !(p[2] && !p[1]) && !(mega && p[19:10] != 10'd0) && sf != 1) begin
        mtlb[m_rr] = '{v: 1'b1, vpn: r.va[31:12], asid: satp[30:22], pte: p, mega: mega};
        m_rr = (m_rr + 1) % N;
      end
    end
    epf = rule_fault(p, mega, r);
    epa = epf ? 34'd0 : rule_pa(p, mega, r.va);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_flush();
    m_rr = 0;
  endtask

  // Drives one request and plays the walker; returns what the DUT reported.
  task automatic run_req(input req_t r, input int wlat, input int sf,
                         output logic [33:0] pa, output logic pf, output bit walked,
                         output int lat, output bit timed_out);
    int wcnt;
    bit done;
    wcnt = 0; done = 1'b0; walked = 1'b0; timed_out = 1'b1;
    pa = '0; pf = 1'b0; lat = 0;
    @(negedge clk);
    address = r.va; access_type = r.acc; privilege_mode = r.priv;
    mxr = r.mxr; sum = r.sum; valid = 1'b1; sfence_vma = (sf == 2);
    @(posedge clk);
    #1;
    valid = 1'b0; sfence_vma = 1'b0;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      walk_ready = 1'b0; sfence_vma = 1'b0;
      if (walk_valid) walked = 1'b1;
      if (ready) begin
        pa = physical_address; pf = page_fault; lat = c; timed_out = 1'b0; done = 1'b1;
      end else if (walk_valid) begin
        wcnt++;
        if (sf == 1 && wcnt == 1) sfence_vma = 1'b1;
        if (wcnt >= wlat) begin
          walk_ready = 1'b1; pte = r.wpte; pte_megapage = r.wmega;
        end
      end
    end
    walk_ready = 1'b0; sfence_vma = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset ready: got %b want 0", ready); end
    checks++; if (page_fault !== 1'b0) begin errors++; $display("FAIL reset page_fault: got %b want 0", page_fault); end
    checks++; if (physical_address !== 34'd0) begin errors++; $display("FAIL reset pa: got %h want 0", physical_address); end
    checks++; if (walk_valid !== 1'b0) begin errors++; $display("FAIL reset walk_valid: got %b want 0", walk_valid); end
  endtask

  task automatic test_bypass();
    req_t r [3];
    logic [33:0] pa, epa; logic pf, epf; bit walked, ewalk, to; int lat;
    r[0] = mkreq(32'h8000_1234, 2'd1, 2'd3, 1'b0, 1'b0, 32'h0, 1'b0);
    r[1] = mkreq(32'hDEAD_BEEF, 2'd2, 2'd1, 1'b0, 1'b0, 32'h0, 1'b0);
    r[2] = mkreq(32'h0000_0FFC, 2'd0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      satp = (i == 0) ? SATP_S5 : 32'h0140_0000;
      predict(r[i], 0, epa, epf, ewalk);
      run_req(r[i], 1, 0, pa, pf, walked, lat, to);
      checks++;
      if (to) begin errors++; $display("FAIL bypass #%0d: no ready within budget", i); end
      else begin
        checks++; if (pa !== epa) begin errors++; $display("FAIL bypass #%0d pa: got %h want %h", i, pa, epa); end
        checks++; if (pf !== 1'b0) begin errors++; $display("FAIL bypass #%0d page_fault: got %b want 0", i, pf); end
        checks++; if (walked) begin errors++; $display("FAIL bypass #%0d walk_valid: got 1 want 0", i); end
        checks++; if (lat != 1) begin errors++; $display("FAIL bypass #%0d latency: got %0d want 1", i, lat); end
      end
      if (i == 0) begin
        checks++; if (pa !== 34'h0_8000_1234) begin errors++; $display("FAIL bypass M-mode pa: got %h want 080001234", pa); end
      end
    end
  endtask

  task automatic test_translate();
    req_t r [12];
    logic [33:0] pa, epa; logic pf, epf; bit walked, ewalk, to; int lat, wl;
    satp = SATP_S5;
    r[0]  = mkreq(32'h0040_0ABC, 2'd0, 2'd1, 1'b0, 1'b0, 32'h2000_04CB, 1'b0);
    r[1]  = r[0];
    r[2]  = mkreq(32'h1000_2000, 2'd2, 2'd0, 1'b0, 1'b0, mk_pte(22'h80002, 8'h57), 1'b0);
    r[3]  = mkreq(32'h1000_2010, 2'd1, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    r[4]  = mkreq(32'h0010_0000, 2'd1, 2'd1, 1'b0, 1'b0, mk_pte(22'h80400, 8'hD3), 1'b1);
    r[5]  = mkreq(32'h0012_3456, 2'd1, 2'd1, 1'b0, 1'b1, 32'h0, 1'b0);
    r[6]  = mkreq(32'h0080_0000, 2'd1, 2'd1, 1'b0, 1'b1, mk_pte(22'h80401, 8'hD3), 1'b1);
    r[7]  = r[6];
    r[8]  = mkreq(32'h2000_0000, 2'd1, 2'd1, 1'b0, 1'b0, mk_pte(22'h80010, 8'hC9), 1'b0);
    r[9]  = mkreq(32'h2000_0000, 2'd1, 2'd1, 1'b1, 1'b0, 32'h0, 1'b0);
    r[10] = mkreq(32'h3000_0000, 2'd1, 2'd1, 1'b0, 1'b0, mk_pte(22'h80020, 8'hC5), 1'b0);
    r[11] = r[10];
    for (int i = 0; i < 12; i++) begin
      wl = (i % 3) + 1;
      predict(r[i], 0, epa, epf, ewalk);
      run_req(r[i], wl, 0, pa, pf, walked, lat, to);
      checks++;
      if (to) begin errors++; $display("FAIL translate #%0d: no ready within budget", i); end
      else begin
        checks++; if (pf !== epf) begin errors++; $display("FAIL translate #%0d page_fault: got %b want %b", i, pf, epf); end
        checks++; if (pa !== epa) begin errors++; $display("FAIL translate #%0d pa: got %h want %h", i, pa, epa); end
        checks++; if (walked !== ewalk) begin errors++; $display("FAIL translate #%0d walked: got %b want %b", i, walked, ewalk); end
        checks++; if (lat != (ewalk ? wl + 2 : 1)) begin errors++; $display("FAIL translate #%0d latency: got %0d want %0d", i, lat, ewalk ? wl + 2 : 1); end
      end
      if (i == 0) begin
        checks++; if (pa !== 34'h0_8000_1ABC) begin errors++; $display("FAIL translate 4K fetch pa: got %h want 080001abc", pa); end
      end
    end
  endtask

  task automatic test_replacement_and_sfence();
    req_t r;
    logic [33:0] pa, epa; logic pf, epf; bit walked, ewalk, to; int lat, sf;
    int pages [9] = '{0, 1, 2, 3, 4, 1, 0, 4, 2};
    satp = SATP_S5;
    for (int i = 0; i < 13; i++) begin
      // Steps 9..12: sfence during a walk of page 5, then earlier pages must all miss.
      if (i < 9) r = mkreq({10'd40, 10'(pages[i]), 12'h010}, 2'd1, 2'd1, 1'b0, 1'b0,
                           mk_pte(22'(32'h90000 + pages[i]), 8'hC3), 1'b0);
      else       r = mkreq({10'd40, 10'(i - 4), 12'h020}, 2'd1, 2'd1, 1'b0, 1'b0,
                           mk_pte(22'(32'h91000 + i), 8'hC3), 1'b0);
      if (i == 9) r.va[21:12] = 10'd5;
      if (i == 10) r.va[21:12] = 10'd5;
      if (i == 11) r.va[21:12] = 10'd1;
      if (i == 12) r.va[21:12] = 10'd4;
      sf = (i == 9) ? 1 : 0;
      predict(r, sf, epa, epf, ewalk);
      run_req(r, 2, sf, pa, pf, walked, lat, to);
      checks++;
      if (to) begin errors++; $display("FAIL replace #%0d: no ready within budget", i); end
      else begin
        checks++; if (pf !== epf) begin errors++; $display("FAIL replace #%0d page_fault: got %b want %b", i, pf, epf); end
        checks++; if (pa !== epa) begin errors++; $display("FAIL replace #%0d pa: got %h want %h", i, pa, epa); end
        checks++; if (walked !== ewalk) begin errors++; $display("FAIL replace #%0d walked: got %b want %b", i, walked, ewalk); end
      end
    end
  endtask

  task automatic test_random();
    req_t r;
    logic [33:0] pa, epa; logic pf, epf; bit walked, ewalk, to; int lat, wl, sf, x;
    logic [21:0] ppn; logic [7:0] flags;
    for (int k = 0; k < 80; k++) begin
      satp = {($urandom_range(0, 9) != 0), 9'($urandom_range(5, 6)), 22'($urandom)};
      x = $urandom_range(0, 9);
      r.priv  = (x == 0) ? 2'd3 : (x < 5) ? 2'd1 : 2'd0;
      r.va    = {10'($urandom_range(0, 3)), 10'($urandom_range(0, 2)), 12'($urandom)};
      r.acc   = 2'($urandom_range(0, 3));
      r.mxr   = 1'($urandom); r.sum = 1'($urandom);
      r.wmega = ($urandom_range(0, 2) == 0);
      ppn     = 22'($urandom);
      if (r.wmega && $urandom_range(0, 3) != 0) ppn[9:0] = 10'd0;
      flags = 8'($urandom);
      if ($urandom_range(0, 9) != 0) flags[0] = 1'b1;
      if ($urandom_range(0, 4) != 0) flags[6] = 1'b1;
      r.wpte = mk_pte(ppn, flags);
      x  = $urandom_range(0, 19);
      sf = (x < 2) ? 1 : (x == 2) ? 2 : 0;
      wl = $urandom_range(1, 3);
      predict(r, sf, epa, epf, ewalk);
      run_req(r, wl, sf, pa, pf, walked, lat, to);
      checks++;
      if (to) begin errors++; $display("FAIL random #%0d: no ready within budget", k); end
      else begin
        checks++; if (pf !== epf) begin errors++; $display("FAIL random #%0d page_fault: got %b want %b (va %h pte %h)", k, pf, epf, r.va, r.wpte); end
        checks++; if (pa !== epa) begin errors++; $display("FAIL random #%0d pa: got %h want %h", k, pa, epa); end
        checks++; if (walked !== ewalk) begin errors++; $display("FAIL random #%0d walked: got %b want %b", k, walked, ewalk); end
        checks++; if (lat != (ewalk ? wl + 2 : 1)) begin errors++; $display("FAIL random #%0d latency: got %0d want %0d", k, lat, ewalk ? wl + 2 : 1); end
      end
    end
  endtask

  task automatic test_reset_mid_walk();
    req_t r;
    logic [33:0] pa, epa; logic pf, epf; bit walked, ewalk, to; int lat;
    apply_reset();
    satp = SATP_S5;
    @(negedge clk);
    address = 32'h0400_5000; access_type = 2'd1; privilege_mode = 2'd1;
    mxr = 1'b0; sum = 1'b0; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    checks++; if (walk_valid !== 1'b1) begin errors++; $display("FAIL midwalk walk_valid before reset: got %b want 1", walk_valid); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (walk_valid !== 1'b0) begin errors++; $display("FAIL midwalk walk_valid after reset: got %b want 0", walk_valid); end
    @(negedge clk);
    reset = 1'b0; walk_ready = 1'b1; pte = mk_pte(22'h80050, 8'hC3); pte_megapage = 1'b0;
    @(negedge clk);
    walk_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (ready !== 1'b0 || walk_valid !== 1'b0) begin errors++; $display("FAIL midwalk late walk_ready: ready %b walk_valid %b want 0 0", ready, walk_valid); end
      @(negedge clk);
    end
    model_flush();
    m_rr = 0;
    r = mkreq(32'h0400_5000, 2'd1, 2'd1, 1'b0, 1'b0, mk_pte(22'h80050, 8'hC3), 1'b0);
    predict(r, 0, epa, epf, ewalk);
    run_req(r, 1, 0, pa, pf, walked, lat, to);
    checks++;
    if (to) begin errors++; $display("FAIL midwalk retry: no ready within budget"); end
    else begin
      checks++; if (pa !== epa || pf !== epf || walked !== ewalk) begin errors++; $display("FAIL midwalk retry: pa %h pf %b walked %b want %h %b %b", pa, pf, walked, epa, epf, ewalk); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; valid = 1'b0; address = '0; access_type = '0; privilege_mode = 2'd3;
    satp = '0; mxr = 1'b0; sum = 1'b0; sfence_vma = 1'b0; walk_ready = 1'b0;
    pte = '0; pte_megapage = 1'b0; m_rr = 0;
    model_flush();
    test_reset();
    test_bypass();
    test_translate();
    test_replacement_and_sfence();
    test_random();
    test_reset_mid_walk();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
